// File: rtl/rm_aligner_pkg.sv
// Shared definitions for the element aligner family.
// - Width helpers: chw (channel index), ofsw (lane offset), ecw (element
//   count 0..n), fifoecw (storage occupancy 0..n), ptrw (storage pointer).
// - elem_t: one storage element.
// - ptr_add: circular pointer advance for buffers of arbitrary depth.
package rm_aligner_pkg;

  localparam int ELEM_W = 64;
  typedef logic [ELEM_W-1:0] elem_t;

  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ofsw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ecw(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int fifoecw(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int ptrw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Advance ptr by inc within [0, depth). Wraps by subtraction so depth need
  // not be a power of two; valid for ptr < depth and inc <= depth.
  function automatic int ptr_add(input int ptr, input int inc, input int depth);
    int sum;
    sum = ptr + inc;
    if (sum >= depth) sum = sum - depth;
    return sum;
  endfunction

endpackage

// File: rtl/rm_aligner_mc_if.sv
// Beat-stream bundle of the multi-channel aligner.
// Handshake: a push fires in a cycle where ival && irdy; a pop fires in a
// cycle where oval && ordy. irdy/oval are combinational on the request fields
// of the same cycle (ich/init/iec, och/oec) and may drop without a transfer.
// - master: beat source / sink side (drives requests, observes status).
// - slave : the aligner.
// Fields: ival/irdy/ich/init/ib/iofs/iec (input beat), oval/ordy/och/ob/
// oofs/oec (output beat), freeec/availec (per-channel occupancy, packed by
// channel, channel 0 in the low bits).
interface rm_aligner_mc_if
  import rm_aligner_pkg::*;
#(
  parameter int EW     = 64,
  parameter int IBEC   = 8,
  parameter int OBEC   = 4,
  parameter int FIFOEC = 16,
  parameter int NCH    = 4
) ();
  localparam int CHW     = chw(NCH);
  localparam int IOFSW   = ofsw(IBEC);
  localparam int IBECW   = ecw(IBEC);
  localparam int OOFSW   = ofsw(OBEC);
  localparam int OBECW   = ecw(OBEC);
  localparam int FIFOECW = fifoecw(FIFOEC);

  logic                     ival;
  logic                     irdy;
  logic [CHW-1:0]           ich;
  logic                     init;
  logic [IBEC*EW-1:0]       ib;
  logic [IOFSW-1:0]         iofs;
  logic [IBECW-1:0]         iec;
  logic                     oval;
  logic                     ordy;
  logic [CHW-1:0]           och;
  logic [OBEC*EW-1:0]       ob;
  logic [OOFSW-1:0]         oofs;
  logic [OBECW-1:0]         oec;
  logic [NCH*FIFOECW-1:0]   freeec;
  logic [NCH*FIFOECW-1:0]   availec;

  modport master (
    output ival, ich, init, ib, iofs, iec, ordy, och, oofs, oec,
    input  irdy, oval, ob, freeec, availec
  );

  modport slave (
    input  ival, ich, init, ib, iofs, iec, ordy, och, oofs, oec,
    output irdy, oval, ob, freeec, availec
  );

endinterface

// File: rtl/rm_aligner_chan.sv
// One aligner channel: circular element buffer with read/write pointers and
// a stored-element count.
// Ports:
// - clk, rst        clock, async active-high reset (pointers/count to 0)
// - push_i          append push_ec_i elements this cycle
// - init_i          with push_i: drop current contents first
// - push_ec_i       number of elements to append
// - push_data_i     elements to append, already packed from lane 0
// - pop_i           remove pop_ec_i oldest elements this cycle
// - pop_ec_i        number of elements to remove
// - rd_data_o       the OBEC oldest slots starting at the read pointer
// - avail_o         registered stored-element count
module rm_aligner_chan
  import rm_aligner_pkg::*;
#(
  parameter int EW     = 64,
  parameter int IBEC   = 8,
  parameter int OBEC   = 4,
  parameter int FIFOEC = 16,
  localparam int IBECW   = ecw(IBEC),
  localparam int OBECW   = ecw(OBEC),
  localparam int FIFOECW = fifoecw(FIFOEC),
  localparam int PW      = ptrw(FIFOEC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic                 init_i,
  input  logic [IBECW-1:0]     push_ec_i,
  input  logic [IBEC*EW-1:0]   push_data_i,
  input  logic                 pop_i,
  input  logic [OBECW-1:0]     pop_ec_i,
  output logic [OBEC*EW-1:0]   rd_data_o,
  output logic [FIFOECW-1:0]   avail_o
);

  logic [PW-1:0]      rptr_q, rptr_d;
  logic [PW-1:0]      wptr_q, wptr_d;
  logic [FIFOECW-1:0] cnt_q, cnt_d;
  logic [EW-1:0]      mem_q [FIFOEC];
  logic [PW-1:0]      widx [IBEC];

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (push_i && init_i) begin
      // Clear wins over a same-cycle pop: the pop has already read the old
      // data combinationally, and the channel restarts at the write pointer.
      rptr_d = wptr_q;
      wptr_d = PW'(ptr_add(int'(wptr_q), int'(push_ec_i), FIFOEC));
      cnt_d  = FIFOECW'(push_ec_i);
    end else begin
      if (pop_i)
        rptr_d = PW'(ptr_add(int'(rptr_q), int'(pop_ec_i), FIFOEC));
      if (push_i)
        wptr_d = PW'(ptr_add(int'(wptr_q), int'(push_ec_i), FIFOEC));
      cnt_d = cnt_q
            + (push_i ? FIFOECW'(push_ec_i) : FIFOECW'(0))
            - (pop_i  ? FIFOECW'(pop_ec_i)  : FIFOECW'(0));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    for (int i = 0; i < IBEC; i++)
      widx[i] = PW'(ptr_add(int'(wptr_q), i, FIFOEC));
  end

  // Element storage carries no reset: occupancy is defined by the pointers.
  always_ff @(posedge clk) begin
    if (push_i) begin
      for (int i = 0; i < IBEC; i++) begin
        if (i < int'(push_ec_i))
          mem_q[widx[i]] <= push_data_i[i*EW +: EW];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < OBEC; j++)
      rd_data_o[j*EW +: EW] = mem_q[PW'(ptr_add(int'(rptr_q), j, FIFOEC))];
  end

  assign avail_o = cnt_q;

endmodule

// File: rtl/rm_aligner_mc.sv
// Multi-channel element realignment FIFO.
// Each of NCH channels accepts IBEC-lane beats carrying the element window
// (iofs, iec) and returns OBEC-lane beats filled at window (oofs, oec).
// Ports:
// - clk, rst  clock, async active-high reset (all channels emptied)
// - bus       rm_aligner_mc_if slave: input beat (ival/irdy/ich/init/ib/
//             iofs/iec), output beat (oval/ordy/och/ob/oofs/oec) and
//             per-channel occupancy (freeec/availec).
// The output beat is combinational from channel storage (no output register);
// unused lanes, and every lane while oval is low, read as 0.
module rm_aligner_mc
  import rm_aligner_pkg::*;
#(
  parameter int EW     = 64,
  parameter int IBEC   = 8,
  parameter int OBEC   = 4,
  parameter int FIFOEC = 16,
  parameter int NCH    = 4,
  parameter int DEBUG  = 0
) (
  input  logic           clk,
  input  logic           rst,
  rm_aligner_mc_if.slave bus
);

  localparam int FIFOECW = fifoecw(FIFOEC);

  logic                  push_fire, pop_fire;
  logic                  irdy, oval;
  logic [IBEC*EW-1:0]    push_data;
  logic [FIFOECW-1:0]    avail_a [NCH];
  logic [OBEC*EW-1:0]    rd_a [NCH];
  logic [NCH-1:0]        push_sel, pop_sel;
  logic [FIFOECW-1:0]    in_avail, out_avail;
  logic [OBEC*EW-1:0]    out_rd;
  logic [OBEC*EW-1:0]    ob_lanes;
  logic [NCH*FIFOECW-1:0] free_v, avail_v;

  // Channel decode and per-request muxing. An out-of-range channel index
  // selects nothing, so no channel is written or read by it.
  always_comb begin
    push_sel  = '0;
    pop_sel   = '0;
    in_avail  = '0;
    out_avail = '0;
    out_rd    = '0;
    for (int c = 0; c < NCH; c++) begin
      if (c == int'(bus.ich)) begin
        push_sel[c] = 1'b1;
        in_avail    = avail_a[c];
      end
      if (c == int'(bus.och)) begin
        pop_sel[c] = 1'b1;
        out_avail  = avail_a[c];
        out_rd     = rd_a[c];
      end
    end
  end

  assign irdy      = bus.init || (int'(bus.iec) <= (FIFOEC - int'(in_avail)));
  assign oval      = int'(bus.oec) <= int'(out_avail);
  assign push_fire = bus.ival && irdy;
  assign pop_fire  = oval && bus.ordy;

  // Pack the input window down to lane 0 so channels always append from
  // their first data lane.
  always_comb begin
    push_data = '0;
    for (int i = 0; i < IBEC; i++) begin
      for (int k = 0; k < IBEC; k++) begin
        if (k == i + int'(bus.iofs))
          push_data[i*EW +: EW] = bus.ib[k*EW +: EW];
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    rm_aligner_chan #(
      .EW     (EW),
      .IBEC   (IBEC),
      .OBEC   (OBEC),
      .FIFOEC (FIFOEC)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push_fire && push_sel[c]),
      .init_i      (bus.init),
      .push_ec_i   (bus.iec),
      .push_data_i (push_data),
      .pop_i       (pop_fire && pop_sel[c]),
      .pop_ec_i    (bus.oec),
      .rd_data_o   (rd_a[c]),
      .avail_o     (avail_a[c])
    );
  end

  // Place the oec oldest elements at lanes oofs.. and zero the rest.
  always_comb begin
    ob_lanes = '0;
    if (oval) begin
      for (int j = 0; j < OBEC; j++) begin
        for (int k = 0; k < OBEC; k++) begin
          if (k < int'(bus.oec) && j == k + int'(bus.oofs))
            ob_lanes[j*EW +: EW] = out_rd[k*EW +: EW];
        end
      end
    end
  end

  always_comb begin
    free_v  = '0;
    avail_v = '0;
    for (int c = 0; c < NCH; c++) begin
      avail_v[c*FIFOECW +: FIFOECW] = avail_a[c];
      free_v[c*FIFOECW +: FIFOECW]  = FIFOECW'(FIFOEC) - avail_a[c];
    end
  end

  assign bus.irdy    = irdy;
  assign bus.oval    = oval;
  assign bus.ob      = ob_lanes;
  assign bus.freeec  = free_v;
  assign bus.availec = avail_v;

  if (DEBUG != 0) begin : g_dbg
    always @(posedge clk) begin
      if (!rst) begin
        if (bus.ival) begin
          assert (int'(bus.iofs) + int'(bus.iec) <= IBEC);
          assert (int'(bus.ich) < NCH);
        end
        if (bus.ordy) begin
          assert (int'(bus.oofs) + int'(bus.oec) <= OBEC);
          assert (int'(bus.och) < NCH);
        end
      end
    end
  end

endmodule

// File: tb/tb_rm_aligner_mc.sv
module tb_rm_aligner_mc;
  import rm_aligner_pkg::*;

  localparam int EW = 64;
  localparam int FW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  rm_aligner_mc_if #(.EW(64), .IBEC(8), .OBEC(4), .FIFOEC(16), .NCH(4)) bus ();

  rm_aligner_mc #(
    .EW(64), .IBEC(8), .OBEC(4), .FIFOEC(16), .NCH(4), .DEBUG(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  function automatic elem_t ev(input int ch, input int k);
    return {8'(ch), 24'hA1B2C3, 32'(k)};
  endfunction

  task automatic drive_idle();
    bus.ival = 1'b0;
    bus.ich  = '0;
    bus.init = 1'b0;
    bus.ib   = '0;
    bus.iofs = '0;
    bus.iec  = '0;
    bus.ordy = 1'b0;
    bus.och  = '0;
    bus.oofs = '0;
    bus.oec  = '0;
  endtask

  task automatic push_cfg(input int ch, input bit ini, input int ofs, input int ec, input int base);
    bus.ival = 1'b1;
    bus.ich  = 2'(ch);
    bus.init = ini;
    bus.iofs = 3'(ofs);
    bus.iec  = 4'(ec);
    for (int i = 0; i < 8; i++) bus.ib[i*EW +: EW] = ev(ch, base + i);
  endtask

  task automatic pop_cfg(input int ch, input int ofs, input int ec);
    bus.ordy = 1'b1;
    bus.och  = 2'(ch);
    bus.oofs = 2'(ofs);
    bus.oec  = 3'(ec);
  endtask

  task automatic apply_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    #1;
    for (int c = 0; c < 4; c++) begin
      n_chk++;
      if (bus.availec[c*FW +: FW] !== 5'd0) begin
        n_err++;
        $display("FAIL reset_availec ch%0d: got %0d expected 0", c, bus.availec[c*FW +: FW]);
      end
      n_chk++;
      if (bus.freeec[c*FW +: FW] !== 5'd16) begin
        n_err++;
        $display("FAIL reset_freeec ch%0d: got %0d expected 16", c, bus.freeec[c*FW +: FW]);
      end
    end
    n_chk++;
    if (bus.oval !== 1'b1) begin n_err++; $display("FAIL reset_oval_oec0: got %b expected 1", bus.oval); end
    n_chk++;
    if (bus.irdy !== 1'b1) begin n_err++; $display("FAIL reset_irdy: got %b expected 1", bus.irdy); end
    n_chk++;
    if (bus.ob !== '0) begin n_err++; $display("FAIL reset_ob: got %h expected 0", bus.ob); end
    bus.oec = 3'd1;
    #1;
    n_chk++;
    if (bus.oval !== 1'b0) begin n_err++; $display("FAIL reset_oval_oec1: got %b expected 0", bus.oval); end
    drive_idle();
    tick();
  endtask

  task automatic test_basic();
    logic [4*EW-1:0] exp_ob;
    push_cfg(0, 1'b0, 2, 5, 0);
    #1;
    n_chk++;
    if (bus.irdy !== 1'b1) begin n_err++; $display("FAIL basic_irdy: got %b expected 1", bus.irdy); end
    tick();
    drive_idle();
    #1;
    n_chk++;
    if (bus.availec[0 +: FW] !== 5'd5) begin n_err++; $display("FAIL basic_avail5: got %0d expected 5", bus.availec[0 +: FW]); end
    pop_cfg(0, 1, 3);
    #1;
    exp_ob = '0;
    exp_ob[1*EW +: EW] = ev(0, 2);
    exp_ob[2*EW +: EW] = ev(0, 3);
    exp_ob[3*EW +: EW] = ev(0, 4);
    n_chk++;
    if (bus.oval !== 1'b1) begin n_err++; $display("FAIL basic_oval: got %b expected 1", bus.oval); end
    n_chk++;
    if (bus.ob !== exp_ob) begin n_err++; $display("FAIL basic_ob: got %h expected %h", bus.ob, exp_ob); end
    tick();
    n_chk++;
    if (bus.availec[0 +: FW] !== 5'd2) begin n_err++; $display("FAIL basic_avail2: got %0d expected 2", bus.availec[0 +: FW]); end
    pop_cfg(0, 2, 2);
    #1;
    exp_ob = '0;
    exp_ob[2*EW +: EW] = ev(0, 5);
    exp_ob[3*EW +: EW] = ev(0, 6);
    n_chk++;
    if (bus.ob !== exp_ob) begin n_err++; $display("FAIL basic_ob_tail: got %h expected %h", bus.ob, exp_ob); end
    tick();
    drive_idle();
    #1;
    n_chk++;
    if (bus.availec[0 +: FW] !== 5'd0) begin n_err++; $display("FAIL basic_drained: got %0d expected 0", bus.availec[0 +: FW]); end
    // Empty channel refuses any nonzero request.
    pop_cfg(0, 0, 1);
    #1;
    n_chk++;
    if (bus.oval !== 1'b0) begin n_err++; $display("FAIL basic_empty_oval: got %b expected 0", bus.oval); end
    drive_idle();
    tick();
  endtask

  task automatic test_full();
    logic [4*EW-1:0] exp_ob;
    push_cfg(1, 1'b0, 0, 8, 0);
    tick();
    push_cfg(1, 1'b0, 0, 8, 8);
    tick();
    drive_idle();
    #1;
    n_chk++;
    if (bus.availec[1*FW +: FW] !== 5'd16) begin n_err++; $display("FAIL full_avail16: got %0d expected 16", bus.availec[1*FW +: FW]); end
    n_chk++;
    if (bus.freeec[1*FW +: FW] !== 5'd0) begin n_err++; $display("FAIL full_free0: got %0d expected 0", bus.freeec[1*FW +: FW]); end
    push_cfg(1, 1'b0, 3, 1, 100);
    #1;
    n_chk++;
    if (bus.irdy !== 1'b0) begin n_err++; $display("FAIL full_irdy: got %b expected 0", bus.irdy); end
    tick();
    n_chk++;
    if (bus.availec[1*FW +: FW] !== 5'd16) begin n_err++; $display("FAIL full_no_push: got %0d expected 16", bus.availec[1*FW +: FW]); end
    bus.init = 1'b1;
    #1;
    n_chk++;
    if (bus.irdy !== 1'b1) begin n_err++; $display("FAIL full_init_irdy: got %b expected 1", bus.irdy); end
    tick();
    drive_idle();
    #1;
    n_chk++;
    if (bus.availec[1*FW +: FW] !== 5'd1) begin n_err++; $display("FAIL full_init_avail: got %0d expected 1", bus.availec[1*FW +: FW]); end
    pop_cfg(1, 0, 1);
    #1;
    exp_ob = '0;
    exp_ob[0 +: EW] = ev(1, 103);
    n_chk++;
    if (bus.ob !== exp_ob) begin n_err++; $display("FAIL full_init_data: got %h expected %h", bus.ob, exp_ob); end
    tick();
    drive_idle();
    tick();
  endtask

  task automatic test_same_cycle();
    logic [4*EW-1:0] exp_ob;
    push_cfg(2, 1'b0, 5, 3, 0);
    tick();
    // Pop 3 and push 8 on ch2 in the same cycle.
    push_cfg(2, 1'b0, 0, 8, 20);
    pop_cfg(2, 1, 3);
    #1;
    exp_ob = '0;
    exp_ob[1*EW +: EW] = ev(2, 5);
    exp_ob[2*EW +: EW] = ev(2, 6);
    exp_ob[3*EW +: EW] = ev(2, 7);
    n_chk++;
    if (bus.irdy !== 1'b1) begin n_err++; $display("FAIL same_irdy: got %b expected 1", bus.irdy); end
    n_chk++;
    if (bus.ob !== exp_ob) begin n_err++; $display("FAIL same_ob_old: got %h expected %h", bus.ob, exp_ob); end
    tick();
    drive_idle();
    #1;
    n_chk++;
    if (bus.availec[2*FW +: FW] !== 5'd8) begin n_err++; $display("FAIL same_avail8: got %0d expected 8", bus.availec[2*FW +: FW]); end
    for (int p = 0; p < 2; p++) begin
      pop_cfg(2, 0, 4);
      #1;
      for (int j = 0; j < 4; j++) exp_ob[j*EW +: EW] = ev(2, 20 + 4*p + j);
      n_chk++;
      if (bus.ob !== exp_ob) begin n_err++; $display("FAIL same_ob_new%0d: got %h expected %h", p, bus.ob, exp_ob); end
      tick();
    end
    // init together with a pop on the same channel.
    drive_idle();
    push_cfg(2, 1'b0, 0, 4, 40);
    tick();
    push_cfg(2, 1'b1, 0, 2, 50);
    pop_cfg(2, 0, 2);
    #1;
    exp_ob = '0;
    exp_ob[0*EW +: EW] = ev(2, 40);
    exp_ob[1*EW +: EW] = ev(2, 41);
    n_chk++;
    if (bus.ob !== exp_ob) begin n_err++; $display("FAIL init_pop_old: got %h expected %h", bus.ob, exp_ob); end
    tick();
    drive_idle();
    #1;
    n_chk++;
    if (bus.availec[2*FW +: FW] !== 5'd2) begin n_err++; $display("FAIL init_pop_avail: got %0d expected 2", bus.availec[2*FW +: FW]); end
    pop_cfg(2, 0, 2);
    #1;
    exp_ob = '0;
    exp_ob[0*EW +: EW] = ev(2, 50);
    exp_ob[1*EW +: EW] = ev(2, 51);
    n_chk++;
    if (bus.ob !== exp_ob) begin n_err++; $display("FAIL init_pop_new: got %h expected %h", bus.ob, exp_ob); end
    tick();
    drive_idle();
    tick();
  endtask

  task automatic test_wrap();
    logic [4*EW-1:0] exp_ob;
    push_cfg(3, 1'b0, 0, 8, 0);
    tick();
    push_cfg(3, 1'b0, 0, 4, 8);
    tick();
    drive_idle();
    for (int p = 0; p < 5; p++) begin
      if (p == 3) begin
        push_cfg(3, 1'b0, 0, 8, 12);
        tick();
        drive_idle();
      end
      pop_cfg(3, 0, 4);
      #1;
      for (int j = 0; j < 4; j++) exp_ob[j*EW +: EW] = ev(3, 4*p + j);
      n_chk++;
      if (bus.ob !== exp_ob) begin n_err++; $display("FAIL wrap_pop%0d: got %h expected %h", p, bus.ob, exp_ob); end
      tick();
    end
    drive_idle();
    #1;
    n_chk++;
    if (bus.availec[3*FW +: FW] !== 5'd0) begin n_err++; $display("FAIL wrap_drained: got %0d expected 0", bus.availec[3*FW +: FW]); end
  endtask

  task automatic test_concurrent();
    elem_t           mq [4][$];
    logic [8*EW-1:0] ib_v;
    logic [4*EW-1:0] exp_ob;
    int pc, qc, iofs, iec, oofs, oec;
    bit ini, ival, ordy, exp_irdy, exp_oval;
    apply_reset();
    for (int n = 0; n < 1500; n++) begin
      pc   = $urandom_range(0, 3);
      qc   = (pc + $urandom_range(1, 3)) % 4;
      iofs = $urandom_range(0, 7);
      iec  = $urandom_range(0, 8 - iofs);
      ini  = ($urandom_range(0, 15) == 0);
      ival = ($urandom_range(0, 3) != 0);
      oec  = $urandom_range(0, 4);
      oofs = $urandom_range(0, 4 - oec);
      ordy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 8; i++) ib_v[i*EW +: EW] = {$urandom, $urandom};
      bus.ival = ival;
      bus.ich  = 2'(pc);
      bus.init = ini;
      bus.iofs = 3'(iofs);
      bus.iec  = 4'(iec);
      bus.ib   = ib_v;
      bus.ordy = ordy;
      bus.och  = 2'(qc);
      bus.oofs = 2'(oofs);
      bus.oec  = 3'(oec);
      #1;
      exp_irdy = ini || (iec <= 16 - mq[pc].size());
      exp_oval = (oec <= mq[qc].size());
      n_chk++;
      if (bus.irdy !== exp_irdy) begin n_err++; $display("FAIL rand_irdy n=%0d: got %b expected %b", n, bus.irdy, exp_irdy); end
      n_chk++;
      if (bus.oval !== exp_oval) begin n_err++; $display("FAIL rand_oval n=%0d: got %b expected %b", n, bus.oval, exp_oval); end
      if (exp_oval) begin
        exp_ob = '0;
        for (int k = 0; k < oec; k++) exp_ob[(oofs + k)*EW +: EW] = mq[qc][k];
        n_chk++;
        if (bus.ob !== exp_ob) begin n_err++; $display("FAIL rand_ob n=%0d: got %h expected %h", n, bus.ob, exp_ob); end
        if (ordy) for (int k = 0; k < oec; k++) void'(mq[qc].pop_front());
      end
      if (ival && exp_irdy) begin
        if (ini) mq[pc].delete();
        for (int i = 0; i < iec; i++) mq[pc].push_back(ib_v[(iofs + i)*EW +: EW]);
      end
      tick();
      for (int c = 0; c < 4; c++) begin
        n_chk++;
        if (int'(bus.availec[c*FW +: FW]) !== mq[c].size()) begin
          n_err++;
          $display("FAIL rand_avail n=%0d ch%0d: got %0d expected %0d", n, c, bus.availec[c*FW +: FW], mq[c].size());
        end
        n_chk++;
        if (int'(bus.freeec[c*FW +: FW]) !== 16 - mq[c].size()) begin
          n_err++;
          $display("FAIL rand_free n=%0d ch%0d: got %0d expected %0d", n, c, bus.freeec[c*FW +: FW], 16 - mq[c].size());
        end
      end
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    logic [4*EW-1:0] exp_ob;
    apply_reset();
    push_cfg(0, 1'b0, 1, 7, 0);
    tick();
    drive_idle();
    pop_cfg(0, 0, 4);
    #1;
    rst = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      n_chk++;
      if (bus.availec[c*FW +: FW] !== 5'd0 || bus.freeec[c*FW +: FW] !== 5'd16) begin
        n_err++;
        $display("FAIL midrst_counts ch%0d: got avail=%0d free=%0d expected 0/16", c, bus.availec[c*FW +: FW], bus.freeec[c*FW +: FW]);
      end
    end
    n_chk++;
    if (bus.oval !== 1'b0) begin n_err++; $display("FAIL midrst_oval: got %b expected 0", bus.oval); end
    n_chk++;
    if (bus.ob !== '0) begin n_err++; $display("FAIL midrst_ob: got %h expected 0", bus.ob); end
    tick();
    tick();
    drive_idle();
    rst = 1'b0;
    tick();
    push_cfg(0, 1'b0, 0, 2, 200);
    tick();
    drive_idle();
    pop_cfg(0, 0, 4);
    #1;
    n_chk++;
    if (bus.oval !== 1'b0) begin n_err++; $display("FAIL midrst_only2_oval: got %b expected 0", bus.oval); end
    pop_cfg(0, 0, 2);
    #1;
    exp_ob = '0;
    exp_ob[0*EW +: EW] = ev(0, 200);
    exp_ob[1*EW +: EW] = ev(0, 201);
    n_chk++;
    if (bus.ob !== exp_ob) begin n_err++; $display("FAIL midrst_fresh: got %h expected %h", bus.ob, exp_ob); end
    tick();
    drive_idle();
    tick();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    drive_idle();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_same_cycle();
    test_wrap();
    test_concurrent();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
